// File: rtl/fifo_read_arbiter.sv
// rtl/fifo_read_arbiter.sv - round-robin burst arbiter sharing one FWFT FIFO read port
module fifo_read_arbiter #(
  parameter int WIDTH = 8,
  parameter int N_REQ = 4,
  parameter int BURST = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [N_REQ-1:0] req_in,
  input  logic             fifo_empty_in,
  input  logic [WIDTH-1:0] fifo_data_in,
  output logic             fifo_read_out,
  output logic [N_REQ-1:0] grant_out,
  output logic [WIDTH-1:0] data_out,
  output logic [N_REQ-1:0] valid_out,
  output logic             busy_out
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(BURST) + 1;

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t           r_state;
  logic [IW-1:0]    r_owner;
  logic [IW-1:0]    r_last;
  logic [CW-1:0]    r_beat;
  logic [N_REQ-1:0] r_grant;
  logic [N_REQ-1:0] r_valid;
  logic [WIDTH-1:0] r_data;

  logic             w_found;
  logic [IW-1:0]    w_winner;
  int               w_idx;
  logic             w_owner_req;
  logic             w_read;
  logic             w_last_beat;

  // Search upward from the slot after the last owner, wrapping at N_REQ.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_idx = (int'(r_last) + k) % N_REQ;
      if (!w_found && req_in[w_idx]) begin
        w_found  = 1'b1;
        w_winner = IW'(w_idx);
      end
    end
  end

  assign w_owner_req = req_in[r_owner];
  assign w_last_beat = (r_beat == CW'(BURST - 1));
  // A read in the reset cycle is suppressed so the FIFO head is not lost.
  assign w_read      = (r_state == S_BURST) & w_owner_req & ~fifo_empty_in & ~rst_in;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= S_IDLE;
      r_owner <= '0;
      r_last  <= IW'(N_REQ - 1);
      r_beat  <= '0;
      r_grant <= '0;
      r_valid <= '0;
      r_data  <= '0;
    end else begin
      r_valid <= '0;
      if (w_read) begin
        r_data  <= fifo_data_in;
        r_valid <= r_grant;
      end
      case (r_state)
        S_IDLE: begin
          if (w_found && !fifo_empty_in) begin
            r_state <= S_BURST;
            r_owner <= w_winner;
            r_grant <= N_REQ'(1) << w_winner;
            r_beat  <= '0;
          end
        end
        S_BURST: begin
          if (!w_owner_req || (w_read && w_last_beat)) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_last  <= r_owner;
          end else if (w_read) begin
            r_beat <= r_beat + CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign fifo_read_out = w_read;
  assign grant_out     = r_grant;
  assign data_out      = r_data;
  assign valid_out     = r_valid;
  assign busy_out      = (r_state == S_BURST);

endmodule

// File: tb/tb_fifo_read_arbiter.sv
// tb/tb_fifo_read_arbiter.sv - directed bench for fifo_read_arbiter with a FWFT FIFO model
module tb_fifo_read_arbiter;

  logic       clk = 1'b0;
  logic       rst_in;
  logic [3:0] req_in;
  logic       fifo_empty_in;
  logic [7:0] fifo_data_in;
  logic       fifo_read_out;
  logic [3:0] grant_out;
  logic [7:0] data_out;
  logic [3:0] valid_out;
  logic       busy_out;

  logic       force_empty;
  logic [7:0] mem [0:63];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  logic       chk_en = 1'b0;
  logic       prev_read = 1'b0;
  int         n_checks = 0;
  int         n_errors = 0;

  fifo_read_arbiter #(.WIDTH(8), .N_REQ(4), .BURST(4)) dut (
    .clk_in        (clk),
    .rst_in        (rst_in),
    .req_in        (req_in),
    .fifo_empty_in (fifo_empty_in),
    .fifo_data_in  (fifo_data_in),
    .fifo_read_out (fifo_read_out),
    .grant_out     (grant_out),
    .data_out      (data_out),
    .valid_out     (valid_out),
    .busy_out      (busy_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (fifo_read_out === 1'b1) rd_ptr <= rd_ptr + 1;

  assign fifo_empty_in = (rd_ptr == wr_ptr) || force_empty;
  assign fifo_data_in  = mem[rd_ptr[5:0]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    mem[wr_ptr[5:0]] = d;
    wr_ptr++;
  endtask

  // Per-cycle invariants at the falling edge, then advance to just past the next rising edge.
  task automatic cyc();
    @(negedge clk);
    if (chk_en) begin
      chk("inv_read_when_empty", 32'(fifo_read_out & fifo_empty_in), 32'd0);
      chk("inv_valid_onehot", 32'($countones(valid_out) <= 1), 32'd1);
      chk("inv_grant_onehot", 32'($countones(grant_out) <= 1), 32'd1);
      chk("inv_valid_follows_read", 32'(|valid_out), 32'(prev_read));
    end
    prev_read = (fifo_read_out === 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [3:0] g, input logic r,
                         input logic [3:0] v, input logic [7:0] d);
    chk({tag, ".grant"}, 32'(grant_out), 32'(g));
    chk({tag, ".read"}, 32'(fifo_read_out), 32'(r));
    chk({tag, ".busy"}, 32'(busy_out), 32'(g != 4'd0));
    chk({tag, ".valid"}, 32'(valid_out), 32'(v));
    if (v != 4'd0) chk({tag, ".data"}, 32'(data_out), 32'(d));
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    req_in = 4'b0000;
    force_empty = 1'b0;
    cyc();
    chk_en = 1'b1;
    cyc();
    chk_out("rst", 4'b0000, 1'b0, 4'b0000, 8'h00);
    chk("rst.data", 32'(data_out), 32'd0);
  endtask

  initial begin
    logic [3:0] g, v;
    logic       r;
    logic [7:0] d;

    // Single requester: two full bursts with one idle cycle between them.
    do_reset();
    for (int i = 0; i < 8; i++) push(8'(8'h10 + i));
    rst_in = 1'b0;
    req_in = 4'b0001;
    #1;
    chk_out("A0", 4'b0000, 1'b0, 4'b0000, 8'h00);
    for (int c = 1; c <= 11; c++) begin
      cyc();
      #1;
      g = ((c >= 1 && c <= 4) || (c >= 6 && c <= 9)) ? 4'b0001 : 4'b0000;
      r = (g != 4'd0);
      v = ((c >= 2 && c <= 5) || (c >= 7 && c <= 10)) ? 4'b0001 : 4'b0000;
      d = 8'(8'h10 + ((c <= 5) ? c - 2 : c - 3));
      chk_out($sformatf("A%0d", c), g, r, v, d);
    end
    req_in = 4'b0000;

    // All requesting, FIFO never empty: owners 0,1,2,3,0, four words each.
    do_reset();
    for (int i = 0; i < 20; i++) push(8'(8'h20 + i));
    rst_in = 1'b0;
    req_in = 4'b1111;
    #1;
    chk_out("B0", 4'b0000, 1'b0, 4'b0000, 8'h00);
    for (int c = 1; c <= 26; c++) begin
      cyc();
      #1;
      g = (((c - 1) % 5) < 4 && c <= 24) ? 4'(1 << (((c - 1) / 5) % 4)) : 4'b0000;
      r = (g != 4'd0);
      v = (c >= 2 && ((c - 2) % 5) < 4 && c <= 25) ? 4'(1 << (((c - 2) / 5) % 4)) : 4'b0000;
      d = 8'(8'h20 + ((c - 2) / 5) * 4 + ((c - 2) % 5));
      chk_out($sformatf("B%0d", c), g, r, v, d);
    end
    req_in = 4'b0000;

    // FIFO runs dry for three cycles after two words; burst stalls then completes.
    do_reset();
    for (int i = 0; i < 4; i++) push(8'(8'h40 + i));
    rst_in = 1'b0;
    req_in = 4'b0001;
    #1;
    chk_out("C0", 4'b0000, 1'b0, 4'b0000, 8'h00);
    for (int c = 1; c <= 9; c++) begin
      cyc();
      force_empty = (c >= 3 && c <= 5);
      #1;
      g = (c <= 7) ? 4'b0001 : 4'b0000;
      r = (c == 1 || c == 2 || c == 6 || c == 7);
      v = (c == 2 || c == 3 || c == 7 || c == 8) ? 4'b0001 : 4'b0000;
      d = (c == 2) ? 8'h40 : (c == 3) ? 8'h41 : (c == 7) ? 8'h42 : 8'h43;
      chk_out($sformatf("C%0d", c), g, r, v, d);
    end
    force_empty = 1'b0;
    req_in = 4'b0000;

    // Owner 1 drops after one word; next grant skips to 3, not 0.
    do_reset();
    push(8'h50);
    push(8'h51);
    rst_in = 1'b0;
    req_in = 4'b1010;
    #1;
    chk_out("D0", 4'b0000, 1'b0, 4'b0000, 8'h00);
    cyc(); #1;                  chk_out("D1", 4'b0010, 1'b1, 4'b0000, 8'h00);
    cyc(); req_in = 4'b1001; #1; chk_out("D2", 4'b0010, 1'b0, 4'b0010, 8'h50);
    cyc(); #1;                  chk_out("D3", 4'b0000, 1'b0, 4'b0000, 8'h00);
    cyc(); #1;                  chk_out("D4", 4'b1000, 1'b1, 4'b0000, 8'h00);
    cyc(); req_in = 4'b0000; #1; chk_out("D5", 4'b1000, 1'b0, 4'b1000, 8'h51);
    cyc(); #1;                  chk_out("D6", 4'b0000, 1'b0, 4'b0000, 8'h00);
    cyc(); #1;                  chk_out("D7", 4'b0000, 1'b0, 4'b0000, 8'h00);

    // Reset during the second beat of a burst to requester 2.
    do_reset();
    for (int i = 0; i < 8; i++) push(8'(8'h60 + i));
    rst_in = 1'b0;
    req_in = 4'b0100;
    #1;
    chk_out("E0", 4'b0000, 1'b0, 4'b0000, 8'h00);
    cyc(); #1;                  chk_out("E1", 4'b0100, 1'b1, 4'b0000, 8'h00);
    cyc(); rst_in = 1'b1; #1;   chk_out("E2", 4'b0100, 1'b0, 4'b0100, 8'h60);
    cyc(); rst_in = 1'b0; req_in = 4'b0101; #1;
    chk_out("E3", 4'b0000, 1'b0, 4'b0000, 8'h00);
    chk("E3.data_cleared", 32'(data_out), 32'd0);
    cyc(); #1;                  chk_out("E4", 4'b0001, 1'b1, 4'b0000, 8'h00);
    cyc(); req_in = 4'b0000; #1; chk_out("E5", 4'b0001, 1'b0, 4'b0001, 8'h61);
    cyc(); #1;                  chk_out("E6", 4'b0000, 1'b0, 4'b0000, 8'h00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fifo_read_arbiter.md
FIFO_READ_ARBITER -- requirements
Module: fifo_read_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits.
REQ-002 Parameter N_REQ, default 4, number of requesters sharing one FIFO read port; legal range 2..8.
REQ-003 Parameter BURST, default 4, maximum words per grant; legal range 1..16.
REQ-004 Interface SHALL be exactly the following ports, clock and reset first.
REQ-005 clk_in  input  1  single clock; all state updates on its rising edge.
REQ-006 rst_in  input  1  reset; synchronous, active-high.
REQ-007 req_in  input  N_REQ  per-requester read request; level, held while the requester wants words.
REQ-008 fifo_empty_in  input  1  FIFO read-side empty flag.
REQ-009 fifo_data_in  input  WIDTH  FIFO head word; valid whenever fifo_empty_in=0 (first-word-fall-through).
REQ-010 fifo_read_out  output  1  FIFO read strobe; head word consumed at the clock edge where it is 1.
REQ-011 grant_out  output  N_REQ  one-hot current owner; all-zero when idle.
REQ-012 data_out  output  WIDTH  registered word delivered to the owner.
REQ-013 valid_out  output  N_REQ  one-hot; bit i=1 for exactly one cycle per word delivered to requester i.
REQ-014 busy_out  output  1  1 while state is BURST.

Function
REQ-015 FSM states SHALL be IDLE and BURST; reset state IDLE.
REQ-016 IDLE: if any req_in bit=1 and fifo_empty_in=0, select a winner round-robin, register grant_out=one-hot(winner), clear beat counter, go to BURST next cycle; otherwise stay IDLE with grant_out=0.
REQ-017 Round-robin: search starts at index (last+1) mod N_REQ and proceeds upward with wrap; last = index of the most recently granted requester; last resets to N_REQ-1, so requester 0 has first priority.
REQ-018 fifo_read_out SHALL equal (state==BURST) & req_in[owner] & ~fifo_empty_in, combinational from registered state and current inputs; never 1 in IDLE.
REQ-019 On each edge with fifo_read_out=1: data_out<=fifo_data_in, valid_out<=grant_out, beat counter increments; otherwise valid_out<=0 and data_out holds.
REQ-020 Read-to-delivery latency SHALL be exactly 1 cycle: valid_out is 1 in the cycle after fifo_read_out=1.
REQ-021 BURST exits to IDLE, clearing grant_out on the same edge, when (a) a read occurs with beat counter == BURST-1, or (b) req_in[owner]=0 in that cycle; last<=owner in both cases.
REQ-022 FIFO empty during BURST: stall; no read, counter holds, grant held, no timeout.
REQ-023 Simultaneous req_in[owner] drop and fifo_empty_in=1: exit per REQ-021(b).
REQ-024 Beat counter width SHALL be clog2(BURST)+1 bits; it never exceeds BURST-1 before exit.
REQ-025 Re-arbitration SHALL take one IDLE cycle; no back-to-back grants without an intervening IDLE cycle.
REQ-026 Requests from non-owners during BURST are ignored until IDLE; no preemption.
REQ-027 At most one fifo_read_out per cycle; valid_out and grant_out SHALL always be one-hot or zero.

Reset
REQ-028 While rst_in=1 at an edge: state<=IDLE, grant_out<=0, valid_out<=0, data_out<=0, beat counter<=0, last<=N_REQ-1; fifo_read_out is 0 throughout reset.
REQ-029 Reset asserted mid-burst SHALL abort the burst; no valid_out is issued for a read in the reset cycle, and the next grant goes to requester 0 if it is requesting.

Verification (N_REQ=4, BURST=4, WIDTH=8)
REQ-030 FIFO holds 0x10..0x17, req_in=4'b0001 held -> grant_out=0001, four reads, valid_out[0] with data 0x10..0x13 on consecutive cycles, one IDLE cycle, then a second burst delivers 0x14..0x17.
REQ-031 req_in=4'b1111 held, FIFO never empty -> grants cycle 0,1,2,3,0, each exactly 4 words, one IDLE cycle between bursts.
REQ-032 Mid-burst fifo_empty_in=1 for 3 cycles after 2 words -> fifo_read_out=0 and grant held for those cycles; the remaining 2 words are delivered after refill, then exit.
REQ-033 Owner drops req_in after 1 word -> exit to IDLE on that edge; next grant goes to the next requesting index above the owner.
REQ-034 rst_in=1 during beat 2 of a burst to requester 2 -> all outputs 0 the next cycle; after release with req_in=4'b0101, requester 0 is granted first.
REQ-035 Checker on every cycle: fifo_read_out never 1 when fifo_empty_in=1; valid_out count equals fifo_read_out count shifted by one cycle.
